portal_msg_deframer: RTL and testbench

//  Downstream of the MAXIGP0 AXI slave bridge's user write pipe. Reassembles the 32-bit

---
 rtl/portal_msg_deframer.sv | 208 ++++++++++++++++++++
 tb/tb_portal_msg_deframer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/portal_msg_deframer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : portal_msg_deframer
// Description : Reassembles the 32-bit portal request word stream coming out
//               of the AXI slave bridge into one wide method message.
//               A header word {methodId[15:0], len[15:0]} is followed by
//               len-1 payload words. The first MAX_WORDS payload words are
//               kept; any extra words are consumed and discarded, and an
//               oversize pulse is raised. The finished message
//               {methodId, payload} is offered on a PipeIn-style ENA/RDY
//               port and held stable until the dispatcher takes it.
// Ports       : CLK           clock, all logic on the rising edge
//               nRST          synchronous reset, active high
//               in_enq__ENA   input word valid
//               in_enq_v      header or payload word
//               in_enq__RDY   deframer can accept a word
//               out_enq__ENA  message transfer (only while out_enq__RDY)
//               out_enq_v     {methodId, payload}
//               out_enq__RDY  dispatcher can accept a message
//               err_oversize  one-cycle pulse: header announced too many words
//               err_count     (DEFRAMER_ERR_COUNT_EN only) saturating count
//                             of err_oversize pulses
// Options     : define DEFRAMER_ERR_COUNT_EN to add the err_count port
// Revision    : 1.0  initial release
// ============================================================================
module portal_msg_deframer #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 16,
    parameter int MAX_WORDS  = 4
) (
    input  logic                                    CLK,
    input  logic                                    nRST,
    input  logic                                    in_enq__ENA,
    input  logic [DATA_WIDTH-1:0]                   in_enq_v,
    output logic                                    in_enq__RDY,
    output logic                                    out_enq__ENA,
    output logic [ID_WIDTH+DATA_WIDTH*MAX_WORDS-1:0] out_enq_v,
    input  logic                                    out_enq__RDY,
    output logic                                    err_oversize
`ifdef DEFRAMER_ERR_COUNT_EN
    ,
    output logic [7:0]                              err_count
`endif
);

    // Header low field carries the total word count (header included).
    localparam int c_LEN_W = DATA_WIDTH - ID_WIDTH;
    // Wide enough to hold MAX_WORDS itself, not just MAX_WORDS-1.
    localparam int c_CNT_W = $clog2(MAX_WORDS + 1);
    localparam int c_PAY_W = DATA_WIDTH * MAX_WORDS;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_COLLECT = 2'd1;
    localparam logic [1:0] c_DRAIN   = 2'd2;
    localparam logic [1:0] c_EMIT    = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;

    logic [ID_WIDTH-1:0] r_method_id;
    logic [c_PAY_W-1:0]  r_payload;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  r_keep;
    logic [c_LEN_W-1:0]  r_drop;
    logic                r_err;

    logic [c_LEN_W-1:0]  w_len;
    logic [c_LEN_W-1:0]  w_npay;
    logic [c_CNT_W-1:0]  w_keep_hdr;
    logic [c_LEN_W-1:0]  w_drop_hdr;
    logic [c_CNT_W-1:0]  w_cnt_inc;
    logic                w_accept;
    logic                w_last_keep;
    logic                w_last_drop;

    // ------------------------------------------------------------------
    // Header decode (only meaningful while in IDLE)
    // ------------------------------------------------------------------
    assign w_len      = in_enq_v[c_LEN_W-1:0];
    // len 0 and len 1 both mean "no payload".
    assign w_npay     = (w_len == '0) ? '0 : w_len - c_LEN_W'(1);
    assign w_keep_hdr = (w_npay > c_LEN_W'(MAX_WORDS)) ? c_CNT_W'(MAX_WORDS)
                                                        : w_npay[c_CNT_W-1:0];
    assign w_drop_hdr = w_npay - c_LEN_W'(w_keep_hdr);

    assign w_accept    = in_enq__ENA && in_enq__RDY;
    assign w_cnt_inc   = r_cnt + c_CNT_W'(1);
    assign w_last_keep = (w_cnt_inc == r_keep);
    assign w_last_drop = (r_drop == c_LEN_W'(1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (nRST) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    if (w_keep_hdr != '0) begin
                        w_state_next = c_COLLECT;
                    end else if (w_drop_hdr != '0) begin
                        w_state_next = c_DRAIN;
                    end else begin
                        w_state_next = c_EMIT;
                    end
                end
            end
            c_COLLECT: begin
                if (w_accept && w_last_keep) begin
                    w_state_next = (r_drop != '0) ? c_DRAIN : c_EMIT;
                end
            end
            c_DRAIN: begin
                if (w_accept && w_last_drop) begin
                    w_state_next = c_EMIT;
                end
            end
            c_EMIT: begin
                if (out_enq__ENA) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Input is stalled only while a finished message waits,
    // which is what keeps words from being lost under backpressure.
    // ------------------------------------------------------------------
    always_comb begin
        in_enq__RDY  = 1'b1;
        out_enq__ENA = 1'b0;
        if (r_state == c_EMIT) begin
            in_enq__RDY  = 1'b0;
            out_enq__ENA = out_enq__RDY;
        end
    end

    // ------------------------------------------------------------------
    // Message datapath and counters
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (nRST) begin
            r_method_id <= '0;
            r_payload   <= '0;
            r_cnt       <= '0;
            r_keep      <= '0;
            r_drop      <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;

            if ((r_state == c_IDLE) && w_accept) begin
                r_method_id <= in_enq_v[DATA_WIDTH-1 -: ID_WIDTH];
                r_payload   <= '0;   // unused slots must read as zero
                r_cnt       <= '0;
                r_keep      <= w_keep_hdr;
                r_drop      <= w_drop_hdr;
                r_err       <= (w_drop_hdr != '0);
            end

            if ((r_state == c_COLLECT) && w_accept) begin
                for (int i = 0; i < MAX_WORDS; i++) begin
                    if (r_cnt == c_CNT_W'(i)) begin
                        r_payload[i*DATA_WIDTH +: DATA_WIDTH] <= in_enq_v;
                    end
                end
                r_cnt <= w_cnt_inc;
            end

            if ((r_state == c_DRAIN) && w_accept) begin
                r_drop <= r_drop - c_LEN_W'(1);
            end
        end
    end

    assign out_enq_v    = {r_method_id, r_payload};
    assign err_oversize = r_err;

`ifdef DEFRAMER_ERR_COUNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge CLK) begin
        if (nRST) begin
            r_err_count <= '0;
        end else if (r_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_portal_msg_deframer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_portal_msg_deframer
// Description : Self-checking bench for portal_msg_deframer. A message-level
//               model (queue of expected messages) is fed from the accepted
//               input words and compared with the DUT every cycle; directed
//               tests add hand-computed literal expectations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_portal_msg_deframer;

    localparam int DW = 32;
    localparam int IW = 16;
    localparam int MW = 4;
    localparam int OW = IW + DW * MW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_ena;
    logic [DW-1:0] in_v;
    logic          in_rdy;
    logic          out_ena;
    logic [OW-1:0] out_v;
    logic          out_rdy;
    logic          err;
`ifdef DEFRAMER_ERR_COUNT_EN
    logic [7:0]    err_count;
`endif

    int n_checks   = 0;
    int n_errors   = 0;
    int err_pulses = 0;

    always #5 clk = ~clk;

    portal_msg_deframer #(
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .MAX_WORDS  (MW)
    ) dut (
        .CLK          (clk),
        .nRST         (rst),
        .in_enq__ENA  (in_ena),
        .in_enq_v     (in_v),
        .in_enq__RDY  (in_rdy),
        .out_enq__ENA (out_ena),
        .out_enq_v    (out_v),
        .out_enq__RDY (out_rdy),
        .err_oversize (err)
`ifdef DEFRAMER_ERR_COUNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Message-level model: words accepted (ENA && RDY) build messages;
    // a finished message sits in exp_q until the dispatcher takes it.
    // ------------------------------------------------------------------
    logic [OW-1:0]   exp_q[$];
    bit              in_msg = 1'b0;
    int              words_left;
    int              slot;
    int              npay;
    logic [IW-1:0]   cur_id;
    logic [DW*MW-1:0] cur_pl;
    logic            err_exp = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            in_msg  = 1'b0;
            err_exp = 1'b0;
        end else begin
            check("in_rdy", OW'(in_rdy), OW'(exp_q.size() == 0));
            check("out_ena", OW'(out_ena), OW'((exp_q.size() != 0) && out_rdy));
            check("err_oversize", OW'(err), OW'(err_exp));
            if (err) err_pulses++;
            err_exp = 1'b0;
            if (exp_q.size() != 0) begin
                check("out_v", out_v, exp_q[0]);
                if (out_rdy) exp_q.delete(0);
            end
            if (in_ena && in_rdy) begin
                if (!in_msg) begin
                    cur_id  = in_v[31:16];
                    npay    = (in_v[15:0] == 16'd0) ? 0 : int'(in_v[15:0]) - 1;
                    cur_pl  = '0;
                    slot    = 0;
                    words_left = npay;
                    err_exp = (npay > MW);
                    if (npay == 0) exp_q.push_back({cur_id, cur_pl});
                    else in_msg = 1'b1;
                end else begin
                    if (slot < MW) cur_pl[slot*DW +: DW] = in_v;
                    slot++;
                    words_left--;
                    if (words_left == 0) begin
                        exp_q.push_back({cur_id, cur_pl});
                        in_msg = 1'b0;
                    end
                end
            end
        end
    end

    // All driving tasks start and end at #1 after a rising edge.
    task automatic send_word(input logic [DW-1:0] w);
        int t;
        t      = 0;
        in_ena = 1'b1;
        in_v   = w;
        @(negedge clk);
        while (!in_rdy && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (!in_rdy) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_word: in_enq__RDY stuck low, word %h", w);
        end
        @(posedge clk);
        #1;
        in_ena = 1'b0;
    endtask

    task automatic wait_emit(output logic [OW-1:0] v);
        int t;
        t = 0;
        @(negedge clk);
        while (!out_ena && t < 50) begin
            t++;
            @(negedge clk);
        end
        n_checks++;
        if (!out_ena) begin
            n_errors++;
            $display("FAIL wait_emit: out_enq__ENA=%b after 50 cycles, expected 1", out_ena);
        end
        v = out_v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    logic [OW-1:0] v;
    logic [OW-1:0] held;
    int            base_pulses;

    initial begin
        rst     = 1'b1;
        in_ena  = 1'b0;
        in_v    = '0;
        out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset in_rdy", OW'(in_rdy), OW'(1));
        check("reset out_ena", OW'(out_ena), OW'(0));
        check("reset out_v", out_v, '0);
        check("reset err", OW'(err), OW'(0));
`ifdef DEFRAMER_ERR_COUNT_EN
        check("reset err_count", OW'(err_count), OW'(0));
`endif
        @(posedge clk);
        #1;

        // 1: two-word message
        send_word(32'h0005_0003);
        send_word(32'hAAAA_0001);
        send_word(32'hBBBB_0002);
        wait_emit(v);
        check("t1 msg", v, {16'h0005, 32'h0, 32'h0, 32'hBBBB_0002, 32'hAAAA_0001});
        check("t1 err pulses", OW'(err_pulses), OW'(0));

        // 2: header-only message, emitted the very next cycle
        send_word(32'h0007_0001);
        @(negedge clk);
        check("t2 latency", OW'(out_ena), OW'(1));
        check("t2 msg", out_v, {16'h0007, 128'h0});
        @(posedge clk);
        #1;

        // 3: oversize, W4/W5 dropped
        send_word(32'h0009_0007);
        for (int i = 0; i < 6; i++) send_word(32'h1000_0000 + i);
        wait_emit(v);
        check("t3 msg", v, {16'h0009, 32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000});
        check("t3 err pulses", OW'(err_pulses), OW'(1));
`ifdef DEFRAMER_ERR_COUNT_EN
        check("t3 err_count", OW'(err_count), OW'(1));
`endif

        // 4: backpressure for 10 cycles, with an illegal ENA while RDY is low
        out_rdy = 1'b0;
        send_word(32'h0004_0003);
        send_word(32'hCCCC_0003);
        send_word(32'hDDDD_0004);
        held   = {16'h0004, 64'h0, 32'hDDDD_0004, 32'hCCCC_0003};
        in_ena = 1'b1;
        in_v   = 32'h0BAD_0002;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4 hold in_rdy", OW'(in_rdy), OW'(0));
            check("t4 hold out_ena", OW'(out_ena), OW'(0));
            check("t4 hold out_v", out_v, held);
        end
        @(posedge clk);
        #1;
        in_ena  = 1'b0;
        out_rdy = 1'b1;
        @(negedge clk);
        check("t4 release out_ena", OW'(out_ena), OW'(1));
        check("t4 release out_v", out_v, held);
        @(posedge clk);
        #1;
        send_word(32'h0003_0001);
        wait_emit(v);
        check("t4 next msg", v, {16'h0003, 128'h0});

        // 5: reset mid-message, partial message never emitted
        send_word(32'h0006_0005);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5 post-reset in_rdy", OW'(in_rdy), OW'(1));
        check("t5 post-reset out_v", out_v, '0);
`ifdef DEFRAMER_ERR_COUNT_EN
        check("t5 post-reset err_count", OW'(err_count), OW'(0));
`endif
        @(posedge clk);
        #1;
        send_word(32'h0002_0002);
        send_word(32'h5A5A_A5A5);
        wait_emit(v);
        check("t5 msg", v, {16'h0002, 96'h0, 32'h5A5A_A5A5});

        // 6: 300 oversize headers, counter saturation
        base_pulses = err_pulses;
        for (int k = 0; k < 300; k++) begin
            send_word(32'h0001_0006);
            for (int j = 0; j < 5; j++) send_word(32'(k * 16 + j));
            wait_emit(v);
        end
        check("t6 err pulses", OW'(err_pulses - base_pulses), OW'(300));
`ifdef DEFRAMER_ERR_COUNT_EN
        check("t6 err_count sat", OW'(err_count), OW'(255));
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
